// File: rtl/fft4_stream.sv
// fft4_stream: streaming radix-4 DFT. Loads four complex samples, computes
// all four bins in a single cycle, then drains them in order k=0..3 under a
// valid/ready handshake on each side.
// Optional build macro FFT4_STREAM_INVERSE_EN adds the 'inv' port, which
// selects an unscaled inverse transform, captured once per frame on a0.
module fft4_stream #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FFT4_STREAM_INVERSE_EN
  input  logic                inv,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] out_re,
  output logic signed [W+1:0] out_im,
  output logic [1:0]          out_idx,
  output logic                out_last
);

  localparam int XW = W + 2;

  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  state_t               state_reg, state_next;
  logic                 armed_reg;      // low for the cycle right after reset
  logic [1:0]           load_cnt_reg;
  logic [1:0]           drain_idx_reg;
  logic signed [W-1:0]  a_re_reg [4];
  logic signed [W-1:0]  a_im_reg [4];
  logic signed [XW-1:0] g_re_reg [4];
  logic signed [XW-1:0] g_im_reg [4];
  logic signed [XW-1:0] g_re_next [4];
  logic signed [XW-1:0] g_im_next [4];
  logic signed [XW-1:0] x_re [4];
  logic signed [XW-1:0] x_im [4];
  logic                 in_fire, out_fire;
`ifdef FFT4_STREAM_INVERSE_EN
  logic                 inv_reg;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register and the post-reset arming flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
    end
  end

  // Next-state decode and handshake flags.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = armed_reg;
        if (in_valid && armed_reg && load_cnt_reg == 2'd3) state_next = CALC;
      end
      CALC: state_next = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && drain_idx_reg == 2'd3) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Sample capture in arrival order; the counter wraps to 0 on the fourth accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_reg <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        a_re_reg[i] <= '0;
        a_im_reg[i] <= '0;
      end
    end else if (in_fire) begin
      load_cnt_reg           <= load_cnt_reg + 2'd1;
      a_re_reg[load_cnt_reg] <= in_re;
      a_im_reg[load_cnt_reg] <= in_im;
    end
  end

`ifdef FFT4_STREAM_INVERSE_EN
  // Direction is latched on the a0 handshake and held for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_reg <= 1'b0;
    end else if (in_fire && load_cnt_reg == 2'd0) begin
      inv_reg <= inv;
    end
  end
`endif

  // Sign-extend every operand so all sums and differences are exact.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
      assign x_re[gi] = {{2{a_re_reg[gi][W-1]}}, a_re_reg[gi]};
      assign x_im[gi] = {{2{a_im_reg[gi][W-1]}}, a_im_reg[gi]};
    end
  endgenerate

  // Two-stage radix-2 butterflies; the -j twiddle is a re/im swap with negation.
  always_comb begin
    logic signed [XW-1:0] b0_re, b0_im, b1_re, b1_im;
    logic signed [XW-1:0] b2_re, b2_im, b3_re, b3_im;
    b0_re = x_re[0] + x_re[2];
    b0_im = x_im[0] + x_im[2];
    b1_re = x_re[0] - x_re[2];
    b1_im = x_im[0] - x_im[2];
    b2_re = x_re[1] + x_re[3];
    b2_im = x_im[1] + x_im[3];
    b3_re = x_re[1] - x_re[3];
    b3_im = x_im[1] - x_im[3];
    g_re_next[0] = b0_re + b2_re;
    g_im_next[0] = b0_im + b2_im;
    g_re_next[1] = b1_re + b3_im;
    g_im_next[1] = b1_im - b3_re;
    g_re_next[2] = b0_re - b2_re;
    g_im_next[2] = b0_im - b2_im;
    g_re_next[3] = b1_re - b3_im;
    g_im_next[3] = b1_im + b3_re;
`ifdef FFT4_STREAM_INVERSE_EN
    // Inverse differs from forward only in the sign of the odd twiddle.
    if (inv_reg) begin
      g_re_next[1] = b1_re - b3_im;
      g_im_next[1] = b1_im + b3_re;
      g_re_next[3] = b1_re + b3_im;
      g_im_next[3] = b1_im - b3_re;
    end
`endif
  end

  // Bin registers load during CALC; the drain index advances per output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_idx_reg <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        g_re_reg[i] <= '0;
        g_im_reg[i] <= '0;
      end
    end else begin
      if (state_reg == CALC) begin
        for (int i = 0; i < 4; i++) begin
          g_re_reg[i] <= g_re_next[i];
          g_im_reg[i] <= g_im_next[i];
        end
      end
      if (out_fire) drain_idx_reg <= drain_idx_reg + 2'd1;
    end
  end

  // Output data is forced to zero whenever no bin is being presented.
  always_comb begin
    out_re   = '0;
    out_im   = '0;
    out_idx  = 2'd0;
    out_last = 1'b0;
    if (out_valid) begin
      out_re   = g_re_reg[drain_idx_reg];
      out_im   = g_im_reg[drain_idx_reg];
      out_idx  = drain_idx_reg;
      out_last = (drain_idx_reg == 2'd3);
    end
  end

endmodule
